// File: rtl/puf_ctrl_pkg.sv
// Shared definitions for the PUF evaluation controller.
// Holds the FSM state encoding, datapath widths, parameter defaults and the
// per-bit vote helpers used when an evaluation sequence completes.
package puf_ctrl_pkg;

    localparam int CHAL_W = 8;   // challenge width
    localparam int RESP_W = 7;   // number of PUF instances / response bits
    localparam int CNT_W  = 4;   // ones / eval counter width
    localparam int PH_W   = 8;   // SETTLE/FIRE phase counter width

    localparam int unsigned SETTLE_CYC_DEF = 32'd2;
    localparam int unsigned PULSE_CYC_DEF  = 32'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        FIRE   = 3'd2,
        SAMPLE = 3'd3,
        RELAX  = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Majority: set when 2*ones > n, so a tie resolves to 0.
    function automatic logic maj_bit(input logic [CNT_W-1:0] ones,
                                     input logic [CNT_W-1:0] n);
        return ({ones, 1'b0} > {1'b0, n});
    endfunction

    // Stable: every evaluation of this bit agreed.
    function automatic logic stable_bit(input logic [CNT_W-1:0] ones,
                                        input logic [CNT_W-1:0] n);
        return (ones == {CNT_W{1'b0}}) || (ones == n);
    endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchroniser for the raw asynchronous PUF responses.
// Ports: clk, rst (async active-high), d_i (raw), q_o (synchronised).
module puf_resp_sync #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage capture of the asynchronous inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {W{1'b0}};
            sync_q <= {W{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// PUF evaluation controller: drives a challenge and race pulse to a 7-instance
// PUF array, repeats the evaluation n times, and majority-votes the responses.
// Ports: clk, rst (async active-high); start, abort, challenge, n_eval in;
// puf_resp (raw async) in; puf_challenge, puf_pulse, busy, done, response,
// stable out. All outputs are registered.
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned PULSE_CYC  = PULSE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CHAL_W-1:0] challenge,
    input  logic [CNT_W-1:0]  n_eval,
    input  logic [RESP_W-1:0] puf_resp,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic              puf_pulse,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] response,
    output logic [RESP_W-1:0] stable
);

    state_e                          state_q, state_d;
    logic [PH_W-1:0]                 cyc_q, cyc_d;
    logic [CNT_W-1:0]                eval_q, eval_d;
    logic [CNT_W-1:0]                n_q, n_d;
    logic [CHAL_W-1:0]               chal_q, chal_d;
    logic [RESP_W-1:0][CNT_W-1:0]    ones_q, ones_d;
    logic                            pulse_q, busy_q, done_q;
    logic [RESP_W-1:0]               resp_q, stab_q;
    logic [RESP_W-1:0]               resp_sync;

    puf_resp_sync #(.W(RESP_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (puf_resp),
        .q_o (resp_sync)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        eval_d  = eval_q;
        n_d     = n_q;
        chal_d  = chal_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SETTLE;
                    cyc_d   = {PH_W{1'b0}};
                    eval_d  = {CNT_W{1'b0}};
                    ones_d  = '0;
                    chal_d  = challenge;
                    n_d     = (n_eval == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : n_eval;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cyc_q == PH_W'(SETTLE_CYC - 32'd1)) begin
                    state_d = FIRE;
                    cyc_d   = {PH_W{1'b0}};
                end else begin
                    cyc_d   = cyc_q + {{(PH_W-1){1'b0}}, 1'b1};
                end
            end
            FIRE: begin
                if (cyc_q == PH_W'(PULSE_CYC - 32'd1)) begin
                    state_d = SAMPLE;
                    cyc_d   = {PH_W{1'b0}};
                end else begin
                    cyc_d   = cyc_q + {{(PH_W-1){1'b0}}, 1'b1};
                end
            end
            SAMPLE: begin
                state_d = RELAX;
                eval_d  = eval_q + {{(CNT_W-1){1'b0}}, 1'b1};
                for (int i = 0; i < RESP_W; i++) begin
                    if (ones_q[i] == {CNT_W{1'b1}}) begin
                        ones_d[i] = ones_q[i];
                    end else begin
                        ones_d[i] = ones_q[i] + {{(CNT_W-1){1'b0}}, resp_sync[i]};
                    end
                end
            end
            RELAX: begin
                cyc_d = {PH_W{1'b0}};
                if (eval_q == n_q) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort overrides everything outside IDLE.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State, counters and latched request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= {PH_W{1'b0}};
            eval_q  <= {CNT_W{1'b0}};
            n_q     <= {CNT_W{1'b0}};
            chal_q  <= {CHAL_W{1'b0}};
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            eval_q  <= eval_d;
            n_q     <= n_d;
            chal_q  <= chal_d;
            ones_q  <= ones_d;
        end
    end

    // Outputs registered from the next state so they align with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= {RESP_W{1'b0}};
            stab_q  <= {RESP_W{1'b0}};
        end else begin
            pulse_q <= (state_d == FIRE) || (state_d == SAMPLE);
            busy_q  <= (state_d == SETTLE) || (state_d == FIRE) ||
                       (state_d == SAMPLE) || (state_d == RELAX);
            done_q  <= (state_d == DONE);
            // Vote is captured on entry to DONE; ones are final by then.
            if ((state_q == RELAX) && (state_d == DONE)) begin
                for (int i = 0; i < RESP_W; i++) begin
                    resp_q[i] <= maj_bit(ones_q[i], n_q);
                    stab_q[i] <= stable_bit(ones_q[i], n_q);
                end
            end else begin
                resp_q <= resp_q;
                stab_q <= stab_q;
            end
        end
    end

    assign puf_challenge = chal_q;
    assign puf_pulse     = pulse_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign response      = resp_q;
    assign stable        = stab_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed self-checking bench for puf_eval_ctrl (default parameters).
module tb_puf_eval_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] challenge;
    logic [3:0] n_eval;
    logic [6:0] puf_resp;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic       busy;
    logic       done;
    logic [6:0] response;
    logic [6:0] stable;

    int checks   = 0;
    int failures = 0;

    logic [6:0] resp_seq [16];
    logic [6:0] prev_resp = 7'h00;
    logic [6:0] prev_stab = 7'h00;

    puf_eval_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .challenge     (challenge),
        .n_eval        (n_eval),
        .puf_resp      (puf_resp),
        .puf_challenge (puf_challenge),
        .puf_pulse     (puf_pulse),
        .busy          (busy),
        .done          (done),
        .response      (response),
        .stable        (stable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts a start and walks the evaluation cycle by cycle. Cycle c is the
    // c-th cycle after the start edge. stop>0 ends the walk at that cycle;
    // start_at>0 pulses start (with a different challenge) in that cycle.
    task automatic run_eval(input logic [7:0] chal, input logic [3:0] n_in,
                            input int n_eff, input int stop, input int start_at,
                            input logic [6:0] exp_resp, input logic [6:0] exp_stab);
        int last;
        int pos;
        last = (stop > 0) ? stop : 7 * n_eff + 1;
        challenge = chal;
        n_eval    = n_in;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int c = 1; c <= last; c++) begin
            pos = (c - 1) % 7;
            if (pos == 0 && c <= 7 * n_eff) puf_resp = resp_seq[(c - 1) / 7];
            if (c == start_at) begin
                start     = 1'b1;
                challenge = ~chal;
            end else begin
                start     = 1'b0;
                challenge = chal;
            end
            check("pulse", {31'd0, puf_pulse}, {31'd0, (pos >= 2 && pos <= 5 && c <= 7 * n_eff)});
            check("busy", {31'd0, busy}, {31'd0, (c <= 7 * n_eff)});
            check("done", {31'd0, done}, {31'd0, (c == 7 * n_eff + 1)});
            check("chal", {24'd0, puf_challenge}, {24'd0, chal});
            if (c < 7 * n_eff + 1) begin
                check("resp_hold", {25'd0, response}, {25'd0, prev_resp});
                check("stab_hold", {25'd0, stable}, {25'd0, prev_stab});
            end else begin
                check("response", {25'd0, response}, {25'd0, exp_resp});
                check("stable", {25'd0, stable}, {25'd0, exp_stab});
                prev_resp = exp_resp;
                prev_stab = exp_stab;
            end
            if (c < last) tick();
        end
        start = 1'b0;
        if (stop == 0) begin
            tick();
            check("post_done", {31'd0, done}, 32'd0);
            check("post_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        challenge = 8'h00; n_eval = 4'd0; puf_resp = 7'h00;
        for (int i = 0; i < 16; i++) resp_seq[i] = 7'h00;
        #1;
        check("rst_pulse", {31'd0, puf_pulse}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_resp", {25'd0, response}, 32'd0);
        check("rst_stab", {25'd0, stable}, 32'd0);
        check("rst_chal", {24'd0, puf_challenge}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // n=1, response 55 held
        resp_seq[0] = 7'h55;
        run_eval(8'hA5, 4'd1, 1, 0, 0, 7'h55, 7'h7F);

        // n=5, bit0 high in evaluations 1-3 only
        resp_seq[0] = 7'h01; resp_seq[1] = 7'h01; resp_seq[2] = 7'h01;
        resp_seq[3] = 7'h00; resp_seq[4] = 7'h00;
        run_eval(8'h3C, 4'd5, 5, 0, 0, 7'h01, 7'h7E);

        // n=4 tie on bit0
        resp_seq[0] = 7'h01; resp_seq[1] = 7'h00; resp_seq[2] = 7'h01; resp_seq[3] = 7'h00;
        run_eval(8'h5A, 4'd4, 4, 0, 0, 7'h00, 7'h7E);

        // n_eval=0 acts as n=1
        resp_seq[0] = 7'h2A;
        run_eval(8'h81, 4'd0, 1, 0, 0, 7'h2A, 7'h7F);

        // abort during FIRE of evaluation 2 (cycle 10)
        resp_seq[0] = 7'h7F; resp_seq[1] = 7'h7F; resp_seq[2] = 7'h7F;
        run_eval(8'hC3, 4'd3, 3, 10, 0, 7'h00, 7'h00);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pulse", {31'd0, puf_pulse}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_resp", {25'd0, response}, 32'h2A);
        check("abort_stab", {25'd0, stable}, 32'h7F);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("abort_nodone", {31'd0, done | busy}, 32'd0);
        end

        // abort together with start in IDLE: not accepted
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", {31'd0, busy}, 32'd0);
        tick();

        // start after abort works; start pulsed while busy is ignored
        resp_seq[0] = 7'h11;
        run_eval(8'h96, 4'd1, 1, 0, 4, 7'h11, 7'h7F);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_second_run", {31'd0, done | busy | puf_pulse}, 32'd0);
        end

        // reset asserted in SAMPLE (cycle 6)
        resp_seq[0] = 7'h7F; resp_seq[1] = 7'h7F;
        run_eval(8'h77, 4'd2, 2, 6, 0, 7'h00, 7'h00);
        rst = 1'b1;
        #1;
        check("mid_rst_pulse", {31'd0, puf_pulse}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_resp", {25'd0, response}, 32'd0);
        check("mid_rst_stab", {25'd0, stable}, 32'd0);
        check("mid_rst_chal", {24'd0, puf_challenge}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_idle", {31'd0, done | busy | puf_pulse}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
